// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand select with bypass, operand register
// feeding the ALU, and a result register toward writeback.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int FUN_W = 4,
  parameter int REG_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1_idx,
  input  logic [REG_W-1:0]  in_rs2_idx,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_op1_sel,
  input  logic              in_op2_sel,
  input  logic [FUN_W-1:0]  in_fun,
  input  logic [REG_W-1:0]  in_rd,
  output logic              alu_valid,
  output logic [2*XLEN-1:0] alu_ops,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [XLEN-1:0]   alu_opd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  out_rd,
  output logic [XLEN-1:0]   out_data
);

  logic              s1_valid_q, s1_valid_d;
  logic [2*XLEN-1:0] s1_ops_q, s1_ops_d;
  logic [FUN_W-1:0]  s1_fun_q, s1_fun_d;
  logic [REG_W-1:0]  s1_rd_q, s1_rd_d;
  logic              s2_valid_q, s2_valid_d;
  logic [REG_W-1:0]  s2_rd_q, s2_rd_d;
  logic [XLEN-1:0]   s2_data_q, s2_data_d;

  logic            s2_free, s1_move, accept;
  logic            s1_live, s2_live;
  logic            s1_hit1, s2_hit1;
  logic            s1_hit2, s2_hit2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op1, op2;

  assign s2_free  = !s2_valid_q | out_ready;
  assign s1_move  = s1_valid_q & s2_free;
  assign in_ready = !s1_valid_q | s2_free;
  assign accept   = in_valid & in_ready & !flush;

  assign s1_live = s1_valid_q && (s1_rd_q != '0);
  assign s2_live = s2_valid_q && (s2_rd_q != '0);
  assign s1_hit1 = s1_live && (s1_rd_q == in_rs1_idx);
  assign s2_hit1 = s2_live && (s2_rd_q == in_rs1_idx);
  assign s1_hit2 = s1_live && (s1_rd_q == in_rs2_idx);
  assign s2_hit2 = s2_live && (s2_rd_q == in_rs2_idx);

  // rs1 bypass: younger S1 result wins over S2
  always_comb begin
    rs1_val = in_rs1;
    unique case (1'b1)
      s1_hit1:            rs1_val = alu_opd;
      s2_hit1 & !s1_hit1: rs1_val = s2_data_q;
      default:            ;
    endcase
  end

  // rs2 bypass: younger S1 result wins over S2
  always_comb begin
    rs2_val = in_rs2;
    unique case (1'b1)
      s1_hit2:            rs2_val = alu_opd;
      s2_hit2 & !s1_hit2: rs2_val = s2_data_q;
      default:            ;
    endcase
  end

  assign op1 = in_op1_sel ? in_pc  : rs1_val;
  assign op2 = in_op2_sel ? in_imm : rs2_val;

  // next state of both entries; flush kills everything
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ops_d   = s1_ops_q;
    s1_fun_d   = s1_fun_q;
    s1_rd_d    = s1_rd_q;
    s2_valid_d = s2_valid_q;
    s2_rd_d    = s2_rd_q;
    s2_data_d  = s2_data_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_valid_q & out_ready) s2_valid_d = 1'b0;
      if (s1_move) begin
        s2_valid_d = 1'b1;
        s2_rd_d    = s1_rd_q;
        s2_data_d  = alu_opd;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_ops_d   = {op2, op1};
        s1_fun_d   = in_fun;
        s1_rd_d    = in_rd;
      end else if (s1_move) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_ops_q   <= '0;
      s1_fun_q   <= '0;
      s1_rd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_rd_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ops_q   <= s1_ops_d;
      s1_fun_q   <= s1_fun_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_rd_q    <= s2_rd_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign alu_valid = s1_valid_q;
  assign alu_ops   = s1_ops_q;
  assign alu_fun   = s1_fun_q;
  assign out_valid = s2_valid_q;
  assign out_rd    = s2_rd_q;
  assign out_data  = s2_data_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Execute-stage front end that sits directly upstream of the combinational ALU. It accepts decoded ALU instructions from decode over a valid/ready handshake and selects the operands. It bypasses in-flight results for RAW hazards and holds each instruction in an operand register that drives the ALU. It captures the ALU result into a result register, which is presented to writeback over a second valid/ready handshake.

Parameters:
XLEN, 32, datapath width; ops and opd widths.
FUN_W, 4, width of the ALU function code.
REG_W, 5, width of register indices.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all in-flight entries.
in_valid  input  1  decode presents an instruction.
in_ready  output  1  stage accepts this cycle.
in_rs1_idx  input  REG_W  source 1 index.
in_rs2_idx  input  REG_W  source 2 index.
in_rs1  input  XLEN  register-file value of rs1.
in_rs2  input  XLEN  register-file value of rs2.
in_imm  input  XLEN  sign-extended immediate.
in_pc  input  XLEN  instruction PC.
in_op1_sel  input  1  0=rs1, 1=pc.
in_op2_sel  input  1  0=rs2, 1=imm.
in_fun  input  FUN_W  ALU function code.
in_rd  input  REG_W  destination index; 0 means no write.
alu_valid  output  1  drives ALU valid.
alu_ops  output  2*XLEN  ops[0]=operand 1, ops[1]=operand 2.
alu_fun  output  FUN_W  drives ALU fun.
alu_opd  input  XLEN  ALU result, combinational from alu_ops/alu_fun.
out_valid  output  1  result available to writeback.
out_ready  input  1  writeback accepts.
out_rd  output  REG_W  destination of result.
out_data  output  XLEN  result value.

Behaviour:
- Two registered entries: S1 is the operand register (valid, ops, fun, rd); S2 is the result register (valid, rd, data).
- Reset (async, reset_n=0):
  - s1_valid=0, s2_valid=0; all data/rd/fun registers cleared to 0.
  - Output values during and after reset, until the first accept: out_valid=0, alu_valid=0, alu_ops=0, alu_fun=0, out_rd=0, out_data=0.
  - in_ready=1 once reset_n=1.
- alu_valid=s1_valid. alu_ops and alu_fun come directly from S1 registers, so the ALU sees stable registered inputs.
- Advance conditions (all combinational):
  - s2_free = !s2_valid | out_ready.
  - s1_move = s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free.
- Each clock edge:
  - If out_valid & out_ready, S2 empties unless s1_move refills it.
  - If s1_move, S2 <= {1, S1.rd, alu_opd}.
  - If in_valid & in_ready, S1 <= the new instruction; else if s1_move, s1_valid <= 0.
- Latency: an instruction accepted at edge N drives the ALU during cycle N..N+1. Its result has out_valid=1 after edge N+1 when there is no back-pressure. Throughput is 1 per cycle.
- Forwarding, applied only to operands selected from rs1/rs2 (not pc/imm), evaluated when the instruction is accepted:
  1. If s1_valid, S1.rd!=0 and S1.rd==rs_idx, use alu_opd.
  2. Else if s2_valid, S2.rd!=0 and S2.rd==rs_idx, use S2.data.
  3. Else use the register-file value.
  - S1 has priority over S2 because it is the younger instruction.
  - Index 0 is never forwarded.
- Back-pressure: when out_ready=0 and S2 is full, S1 holds and in_ready=0. S1 holds its ops, so alu_opd stays stable. No data is lost or duplicated.
- Flush:
  - Next edge: s1_valid=0 and s2_valid=0. in_valid is ignored that cycle, with no accept.
  - in_ready may read 1 during the flush cycle, but no accept occurs.
  - Flush overrides all simultaneous handshakes.
- Reset mid-operation: all entries are dropped immediately (asynchronous); no partial result is emitted.
- Arithmetic: no width conversion; operands pass through at XLEN. An unknown fun is passed unchanged; the result is whatever the ALU returns.

Test Plan:
1. ADD with rs1=5, rs2=7 (op sels 0,0), rd=3, out_ready=1 -> alu_ops={7,5} the cycle after accept; out_valid=1, out_rd=3, out_data=12 one edge later.
2. Back-to-back dependency: ADD x1=10+20, then SUB x2=x1-imm 4 (op2_sel=1, in_rs1=0 stale) -> second result 26; S1 forward used.
3. Gap-of-one dependency:
   - Sequence: ADD x1=1+2; unrelated XOR x5; then SLT x6=x1<x0 (in_rs1 stale 99).
   - Required: the S2-forwarded value 3 is used; SLT result 0.
4. rd=0 hazard: ADD x0=8+8, then ADD x4=x0+1 with in_rs1=0 -> result 1 (no forward from x0).
5. Back-pressure:
   - Stimulus: out_ready=0 with 3 instructions offered (results 1, 2, 3).
   - Required: S2 holds 1, S1 holds the second, in_ready=0, the third is stalled.
   - Release out_ready -> 1, 2, 3 are delivered in order with no duplicates.
6. Flush with S1 and S2 full, and reset_n pulsed low mid-stream:
   - flush -> out_valid=0 and alu_valid=0 next edge.
   - reset_n low -> outputs 0 immediately; after release, in_ready=1.
